// File: rtl/mem_responder_if.sv
// Memory bus between a CPU-side initiator and the memory responder.
// The initiator drives the request fields; the responder answers with data, ready, err and busy.
interface mem_responder_if #(
  parameter int DATA_W = 16
);
  logic              req;
  logic              we;
  logic [15:0]       addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ready;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ready, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ready, err, busy
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM that serves one request at a time, answering after WAIT_STATES
// wait cycles with a one-cycle ready strobe and flagging out-of-range addresses.
module mem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_responder_if.slave    bus
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] WS_INIT = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t            state;
  logic [3:0]        cnt;
  logic              we_l;
  logic [15:0]       addr_l;
  logic [DATA_W-1:0] wdata_l;
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r;
  logic              err_r;
  logic              busy_r;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  logic              acc_fire;
  logic              acc_we;
  logic [15:0]       acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              acc_ok;

  // Any address bit above the implemented RAM makes the access out of range.
  function automatic logic in_range(input logic [15:0] a);
    return a[15:ADDR_W] == '0;
  endfunction

  // With zero wait states the access happens on the accepting edge, so the live
  // bus fields are used; otherwise the copies latched at accept time are used.
  always_comb begin
    acc_fire  = 1'b0;
    acc_we    = we_l;
    acc_addr  = addr_l;
    acc_wdata = wdata_l;
    if (state == S_IDLE && bus.req && WAIT_STATES == 0) begin
      acc_fire  = 1'b1;
      acc_we    = bus.we;
      acc_addr  = bus.addr;
      acc_wdata = bus.wdata;
    end else if (state == S_WAIT && cnt == 4'd0) begin
      acc_fire  = 1'b1;
    end
  end

  assign acc_ok = in_range(acc_addr);

  always_ff @(posedge clk) begin
    if (!rst && acc_fire && acc_we && acc_ok)
      mem[acc_addr[ADDR_W-1:0]] <= acc_wdata;
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && bus.req) begin
      we_l    <= bus.we;
      addr_l  <= bus.addr;
      wdata_l <= bus.wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      rdata_r <= '0;
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      ready_r <= 1'b0;
      err_r   <= 1'b0;
      if (acc_fire) begin
        ready_r <= 1'b1;
        err_r   <= !acc_ok;
        if (!acc_ok)
          rdata_r <= '0;
        else if (acc_we)
          rdata_r <= acc_wdata;
        else
          rdata_r <= mem[acc_addr[ADDR_W-1:0]];
      end
      case (state)
        S_IDLE: begin
          if (bus.req) begin
            busy_r <= 1'b1;
            if (WAIT_STATES == 0) begin
              state <= S_RESP;
            end else begin
              state <= S_WAIT;
              cnt   <= WS_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt != 4'd0)
            cnt <= cnt - 4'd1;
          else
            state <= S_RESP;
        end
        S_RESP: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.rdata = rdata_r;
  assign bus.ready = ready_r;
  assign bus.err   = err_r;
  assign bus.busy  = busy_r;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if #(.DATA_W(16)) b2 ();
  mem_responder_if #(.DATA_W(16)) b0 ();

  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(2)) dut2 (
    .clk(clk), .rst(rst), .bus(b2.slave)
  );
  mem_responder #(.DATA_W(16), .ADDR_W(8), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .bus(b0.slave)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    bit          s0;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    bit          exp_err;
  } vec_t;

  vec_t tbl [16];

  task automatic drive(input bit s0, input bit r, input bit w, input logic [15:0] a,
                       input logic [15:0] d);
    if (s0) begin
      b0.req = r; b0.we = w; b0.addr = a; b0.wdata = d;
    end else begin
      b2.req = r; b2.we = w; b2.addr = a; b2.wdata = d;
    end
  endtask

  // One transaction: raise req, count edges until ready (bounded), then drop req.
  task automatic txn(input bit s0, input bit w, input logic [15:0] a, input logic [15:0] d,
                     output logic [15:0] rd, output logic e, output int lat);
    bit seen;
    @(negedge clk);
    drive(s0, 1'b1, w, a, d);
    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      seen = s0 ? b0.ready : b2.ready;
    end
    rd = s0 ? b0.rdata : b2.rdata;
    e  = s0 ? b0.err : b2.err;
    @(negedge clk);
    drive(s0, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;
  int          nrdy;
  int          nseen;
  bit          prev_rdy;
  logic [15:0] exp_c [3];

  initial begin
    tbl[0]  = '{0, 1, 16'h0000, 16'h1234, 16'h1234, 0};
    tbl[1]  = '{0, 1, 16'h0006, 16'h6666, 16'h6666, 0};
    tbl[2]  = '{0, 0, 16'h0005, 16'h0000, 16'hBEEF, 0};
    tbl[3]  = '{0, 0, 16'h0100, 16'h0000, 16'h0000, 1};
    tbl[4]  = '{0, 1, 16'h0100, 16'hDEAD, 16'h0000, 1};
    tbl[5]  = '{0, 0, 16'h0000, 16'h0000, 16'h1234, 0};
    tbl[6]  = '{0, 1, 16'h0007, 16'h5555, 16'h5555, 0};
    tbl[7]  = '{0, 1, 16'hFFFF, 16'h1111, 16'h0000, 1};
    tbl[8]  = '{0, 1, 16'h00FF, 16'h0F0F, 16'h0F0F, 0};
    tbl[9]  = '{0, 0, 16'h00FF, 16'h0000, 16'h0F0F, 0};
    tbl[10] = '{0, 1, 16'h0001, 16'h1111, 16'h1111, 0};
    tbl[11] = '{0, 1, 16'h0002, 16'h2222, 16'h2222, 0};
    tbl[12] = '{0, 1, 16'h0003, 16'h3333, 16'h3333, 0};
    tbl[13] = '{1, 1, 16'h0010, 16'hCAFE, 16'hCAFE, 0};
    tbl[14] = '{1, 0, 16'h0010, 16'h0000, 16'hCAFE, 0};
    tbl[15] = '{1, 0, 16'h0200, 16'h0000, 16'h0000, 1};
    exp_c[0] = 16'h1111; exp_c[1] = 16'h2222; exp_c[2] = 16'h3333;

    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ready", b2.ready, 0);
    check("reset_err",   b2.err,   0);
    check("reset_busy",  b2.busy,  0);
    check("reset_rdata", b2.rdata, 0);
    check("reset_busy0", b0.busy,  0);
    @(negedge clk);
    rst = 1'b0;

    // Write 0x0005=0xBEEF: ready only after edge 2, busy after edges 0..2.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0005, 16'hBEEF);
    for (int ed = 0; ed < 5; ed++) begin
      @(posedge clk);
      #1;
      check($sformatf("wr5_ready_e%0d", ed), b2.ready, (ed == 2) ? 1 : 0);
      check($sformatf("wr5_busy_e%0d", ed), b2.busy, (ed <= 2) ? 1 : 0);
      if (ed == 2) begin
        check("wr5_rdata", b2.rdata, 16'hBEEF);
        check("wr5_err", b2.err, 0);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
      end
    end

    for (int i = 0; i < 16; i++) begin
      txn(tbl[i].s0, tbl[i].we, tbl[i].addr, tbl[i].wdata, rd, e, lat);
      check($sformatf("vec%0d_latency", i), lat, tbl[i].s0 ? 1 : 3);
      check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rd);
      check($sformatf("vec%0d_err", i), e, tbl[i].exp_err);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ready_drop", i), tbl[i].s0 ? b0.ready : b2.ready, 0);
      check($sformatf("vec%0d_idle", i), tbl[i].s0 ? b0.busy : b2.busy, 0);
    end

    // Address changes during WAIT must not affect the access.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0005, 16'h0000);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000);
    @(posedge clk);
    #1;
    check("addr_chg_busy", b2.busy, 1);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000);
    @(posedge clk);
    #1;
    check("addr_chg_ready", b2.ready, 1);
    check("addr_chg_rdata", b2.rdata, 16'hBEEF);
    @(posedge clk);

    // req held high for three reads: one ready every 4 cycles, in order.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000);
    nseen = 0;
    prev_rdy = 1'b0;
    for (int ed = 0; ed < 12; ed++) begin
      @(posedge clk);
      #1;
      if (b2.ready) begin
        check($sformatf("b2b_edge_%0d", nseen), ed, 2 + 4 * nseen);
        check($sformatf("b2b_rdata_%0d", nseen), b2.rdata, (nseen < 3) ? exp_c[nseen] : 16'hXXXX);
        check("b2b_no_double", prev_rdy, 0);
        nseen++;
        @(negedge clk);
        if (nseen >= 3) drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        else            drive(1'b0, 1'b1, 1'b0, 16'h0001 + 16'(nseen), 16'h0000);
      end
      prev_rdy = b2.ready;
    end
    check("b2b_count", nseen, 3);

    // Reset in the second WAIT cycle aborts a write to 0x0007.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 16'h0007, 16'hAAAA);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("abort_busy_wait", b2.busy, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_ready", b2.ready, 0);
    check("abort_err",   b2.err,   0);
    check("abort_busy",  b2.busy,  0);
    check("abort_rdata", b2.rdata, 0);
    @(negedge clk);
    rst = 1'b0;
    nrdy = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (b2.ready) nrdy++;
    end
    check("abort_no_ready", nrdy, 0);
    txn(1'b0, 1'b0, 16'h0007, 16'h0000, rd, e, lat);
    check("abort_latency", lat, 3);
    check("abort_old_value", rd, 16'h5555);

    // Zero wait states with req held: ready every other cycle.
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b0, 16'h0010, 16'h0000);
    for (int ed = 0; ed < 6; ed++) begin
      @(posedge clk);
      #1;
      check($sformatf("ws0_ready_e%0d", ed), b0.ready, (ed % 2 == 0) ? 1 : 0);
      if (ed % 2 == 0) check($sformatf("ws0_rdata_e%0d", ed), b0.rdata, 16'hCAFE);
    end
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
    @(posedge clk);
    #1;
    check("ws0_idle", b0.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
